// File: rtl/write_back_pipe_if.sv
// Purpose : bundles the MEM/WB-side inputs and register-file-side outputs of write_back_pipe.
// Latency : n/a (signal bundle only).
// Backpr. : in_valid/in_ready upstream, w_valid/out_ready downstream.
// Ports   : master = upstream stage + register file side, slave = write_back_pipe.
interface write_back_pipe_if #(
  parameter int WORD      = 64,
  parameter int REG_ADDR  = 5,
  parameter int INST_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD-1:0]      ALUOut;
  logic [WORD-1:0]      r_data;
  logic [WORD-1:0]      pc_incr;
  logic [WORD-1:0]      r_data2;
  logic [1:0]           MemtoReg;
  logic [1:0]           ld_size;
  logic                 ld_sign;
  logic                 RegWrite;
  logic [INST_SIZE-1:0] inst;
  logic                 out_ready;
  logic                 w_valid;
  logic                 w_en;
  logic [REG_ADDR-1:0]  w_addr;
  logic [WORD-1:0]      w_data;
  logic                 illegal_hw;

  modport master (
    output in_valid, ALUOut, r_data, pc_incr, r_data2, MemtoReg, ld_size, ld_sign,
           RegWrite, inst, out_ready,
    input  in_ready, w_valid, w_en, w_addr, w_data, illegal_hw
  );

  modport slave (
    input  in_valid, ALUOut, r_data, pc_incr, r_data2, MemtoReg, ld_size, ld_sign,
           RegWrite, inst, out_ready,
    output in_ready, w_valid, w_en, w_addr, w_data, illegal_hw
  );
endinterface

// File: rtl/write_back_pipe.sv
// Purpose : LEGv8 write-back stage: source select, load extension, MOVZ/MOVN/MOVK, registered result.
// Latency : 1 cycle from acceptance to w_valid; 1 result per cycle while out_ready is high.
// Backpr. : while w_valid && !out_ready all outputs freeze and in_ready drops.
// Ports   : clk, rst (async, active-high); bus (slave modport) carries handshake, datapath
//           inputs, and the w_valid/w_en/w_addr/w_data/illegal_hw register-file outputs.
module write_back_pipe #(
  parameter int WORD      = 64,
  parameter int REG_ADDR  = 5,
  parameter int INST_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  write_back_pipe_if.slave  bus
);

  logic                w_valid_q, w_valid_d;
  logic                w_en_q, w_en_d;
  logic [REG_ADDR-1:0] w_addr_q, w_addr_d;
  logic [WORD-1:0]     w_data_q, w_data_d;
  logic                illegal_q, illegal_d;

  logic                in_ready;
  logic                accept;
  logic [1:0]          hw;
  logic [15:0]         imm16;
  logic [4:0]          rd;
  logic [5:0]          sh;
  logic                hw_ok;
  logic [WORD-1:0]     imm_sh;
  logic [WORD-1:0]     mask;
  logic                fwd;
  logic [WORD-1:0]     base;
  logic                is_mov;
  logic [WORD-1:0]     mov_val;
  logic [6:0]          ld_shamt;
  logic [WORD-1:0]     ld_tmp;
  logic [WORD-1:0]     ld_val;
  logic [WORD-1:0]     sel_val;
  logic                illegal;

  // in_ready looks only at registered state and out_ready, never at in_valid.
  assign in_ready = !w_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    hw     = bus.inst[22:21];
    imm16  = bus.inst[20:5];
    rd     = bus.inst[4:0];
    sh     = {hw, 4'b0000};
    hw_ok  = ({30'd0, hw} < WORD / 16);
    imm_sh = WORD'(imm16) << sh;
    mask   = WORD'(16'hFFFF) << sh;

    // MOVK merges into the result still sitting in this stage when it targets the
    // same register, because the register file has not seen that write yet.
    fwd  = w_valid_q && w_en_q && (w_addr_q == REG_ADDR'(rd));
    base = fwd ? w_data_q : bus.r_data2;

    is_mov  = 1'b0;
    mov_val = '0;
    casez (bus.inst[31:21])
      11'b110100101??: begin is_mov = 1'b1; mov_val = imm_sh;                   end
      11'b100100101??: begin is_mov = 1'b1; mov_val = ~imm_sh;                  end
      11'b111100101??: begin is_mov = 1'b1; mov_val = (base & ~mask) | imm_sh;  end
      default: ;
    endcase

    // Extension by shifting the item to the top and back down; a zero shift
    // (64-bit load, or 32-bit load on a 32-bit datapath) passes r_data through.
    case (bus.ld_size)
      2'd0:    ld_shamt = 7'(WORD - 8);
      2'd1:    ld_shamt = 7'(WORD - 16);
      2'd2:    ld_shamt = 7'(WORD - 32);
      default: ld_shamt = 7'd0;
    endcase
    ld_tmp = bus.r_data << ld_shamt;
    if (bus.ld_sign) ld_val = $unsigned($signed(ld_tmp) >>> ld_shamt);
    else             ld_val = ld_tmp >> ld_shamt;

    case (bus.MemtoReg)
      2'd0:    sel_val = bus.ALUOut;
      2'd1:    sel_val = ld_val;
      2'd2:    sel_val = bus.pc_incr;
      default: sel_val = '0;
    endcase

    illegal = is_mov && !hw_ok;

    w_valid_d = w_valid_q;
    w_en_d    = w_en_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    illegal_d = illegal_q;
    if (accept) begin
      w_valid_d = 1'b1;
      w_en_d    = bus.RegWrite && (rd != 5'd31) && !illegal;
      w_addr_d  = REG_ADDR'(rd);
      w_data_d  = illegal ? '0 : (is_mov ? mov_val : sel_val);
      illegal_d = illegal;
    end else if (bus.out_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      w_valid_q <= w_valid_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.w_valid    = w_valid_q;
  assign bus.w_en       = w_en_q && w_valid_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign bus.illegal_hw = illegal_q && w_valid_q;

endmodule

// File: tb/tb_write_back_pipe.sv
// Purpose : scoreboard bench for write_back_pipe at WORD=64 and WORD=32.
// Latency : checks each accepted result appears one cycle later and is compared on drain.
// Backpr. : exercises held outputs under out_ready=0 and async reset discard.
module tb_write_back_pipe;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  addr;
    logic        en;
    logic        ill;
  } exp_t;

  localparam logic [8:0] OP_ADD  = 9'b100010110;
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVN = 9'b100100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [63:0] alu, rdat, pc, rdat2;
  logic [1:0]  m2r, lsz;
  logic        lsgn, rw, ordy, iv64, iv32;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q64[$];
  exp_t q32[$];
  exp_t m64, m32;

  always #5 clk = ~clk;

  write_back_pipe_if #(.WORD(64), .REG_ADDR(5), .INST_SIZE(32)) if64 ();
  write_back_pipe_if #(.WORD(32), .REG_ADDR(5), .INST_SIZE(32)) if32 ();

  assign if64.in_valid  = iv64;
  assign if64.ALUOut    = alu;
  assign if64.r_data    = rdat;
  assign if64.pc_incr   = pc;
  assign if64.r_data2   = rdat2;
  assign if64.MemtoReg  = m2r;
  assign if64.ld_size   = lsz;
  assign if64.ld_sign   = lsgn;
  assign if64.RegWrite  = rw;
  assign if64.inst      = inst;
  assign if64.out_ready = ordy;

  assign if32.in_valid  = iv32;
  assign if32.ALUOut    = alu[31:0];
  assign if32.r_data    = rdat[31:0];
  assign if32.pc_incr   = pc[31:0];
  assign if32.r_data2   = rdat2[31:0];
  assign if32.MemtoReg  = m2r;
  assign if32.ld_size   = lsz;
  assign if32.ld_sign   = lsgn;
  assign if32.RegWrite  = rw;
  assign if32.inst      = inst;
  assign if32.out_ready = ordy;

  write_back_pipe #(.WORD(64), .REG_ADDR(5), .INST_SIZE(32)) u64 (.clk(clk), .rst(rst), .bus(if64));
  write_back_pipe #(.WORD(32), .REG_ADDR(5), .INST_SIZE(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [8:0] op, input logic [1:0] hw,
                                     input logic [15:0] imm, input logic [4:0] rd);
    return {op, hw, imm, rd};
  endfunction

  // Presents one instruction to the selected DUT, waits (bounded) for acceptance,
  // queues the expected result and checks it appears one cycle later.
  task automatic send(input bit sel, input logic [31:0] i_inst, input logic [1:0] i_m2r,
                      input logic [1:0] i_lsz, input logic i_lsgn, input logic i_rw,
                      input logic [63:0] i_alu, input logic [63:0] i_rd, input logic [63:0] i_rd2,
                      input logic [63:0] e_data, input logic e_en, input logic e_ill);
    exp_t e;
    bit   done;
    inst = i_inst; m2r = i_m2r; lsz = i_lsz; lsgn = i_lsgn; rw = i_rw;
    alu = i_alu; rdat = i_rd; rdat2 = i_rd2; pc = 64'h0;
    if (sel) iv32 = 1'b1; else iv64 = 1'b1;
    e.data = e_data; e.addr = i_inst[4:0]; e.en = e_en; e.ill = e_ill;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if ((sel ? if32.in_ready : if64.in_ready) === 1'b1) begin
        if (sel) q32.push_back(e); else q64.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    iv64 = 1'b0; iv32 = 1'b0;
    chk("accept", 64'(done), 64'd1);
    if (done) chk("latency", 64'(sel ? if32.w_valid : if64.w_valid), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && if64.w_valid && ordy) begin
      chk("q64_avail", 64'(q64.size() != 0), 64'd1);
      if (q64.size() != 0) begin
        m64 = q64.pop_front();
        chk("w_data64", if64.w_data, m64.data);
        chk("w_addr64", 64'(if64.w_addr), 64'(m64.addr));
        chk("w_en64", 64'(if64.w_en), 64'(m64.en));
        chk("ill64", 64'(if64.illegal_hw), 64'(m64.ill));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if32.w_valid && ordy) begin
      chk("q32_avail", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        m32 = q32.pop_front();
        chk("w_data32", 64'(if32.w_data), m32.data);
        chk("w_addr32", 64'(if32.w_addr), 64'(m32.addr));
        chk("w_en32", 64'(if32.w_en), 64'(m32.en));
        chk("ill32", 64'(if32.illegal_hw), 64'(m32.ill));
      end
    end
  end

  initial begin
    rst = 1'b1; ordy = 1'b1; iv64 = 1'b0; iv32 = 1'b0;
    inst = 32'h0; alu = '0; rdat = '0; pc = '0; rdat2 = '0;
    m2r = 2'd0; lsz = 2'd0; lsgn = 1'b0; rw = 1'b0;

    @(negedge clk);
    chk("rst_w_valid", 64'(if64.w_valid), 64'd0);
    chk("rst_w_data", if64.w_data, 64'd0);
    chk("rst_w_en", 64'(if64.w_en), 64'd0);
    chk("rst_w_addr", 64'(if64.w_addr), 64'd0);
    chk("rst_ill", 64'(if64.illegal_hw), 64'd0);
    chk("rst_in_ready", 64'(if64.in_ready), 64'd1);
    chk("rst_w_valid32", 64'(if32.w_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Source select and load extension, WORD=64
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd3), 2'd0, 2'd0, 1'b0, 1'b1, 64'h1234, 64'h0, 64'h0, 64'h1234, 1'b1, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd1, 2'd0, 1'b1, 1'b1, 64'h0, 64'h80F0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd1, 2'd1, 1'b0, 1'b1, 64'h0, 64'h80F0, 64'h0, 64'h80F0, 1'b1, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd1, 2'd2, 1'b1, 1'b1, 64'h0, 64'hABCD_0000_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd1, 2'd3, 1'b1, 1'b1, 64'h0, 64'h8765_4321_0000_00FF, 64'h0, 64'h8765_4321_0000_00FF, 1'b1, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd3, 2'd0, 1'b0, 1'b1, 64'h55, 64'h66, 64'h0, 64'h0, 1'b1, 1'b0);

    // MOV group, WORD=64
    send(0, mk(OP_MOVZ, 2'd2, 16'hBEEF, 5'd6), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0000_BEEF_0000_0000, 1'b1, 1'b0);
    send(0, mk(OP_MOVN, 2'd0, 16'h0001, 5'd6), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    send(0, mk(OP_MOVK, 2'd1, 16'hAAAA, 5'd7), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h1111_2222_AAAA_4444, 1'b1, 1'b0);

    // MOVK forwarding across one stalled cycle
    send(0, mk(OP_MOVZ, 2'd0, 16'h00FF, 5'd5), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
    ordy = 1'b0;
    inst = mk(OP_MOVK, 2'd3, 16'h1234, 5'd5); rdat2 = 64'h0; iv64 = 1'b1;
    @(posedge clk); #1;
    chk("fwd_stall_rdy", 64'(if64.in_ready), 64'd0);
    chk("fwd_stall_data", if64.w_data, 64'h0000_0000_0000_00FF);
    ordy = 1'b1;
    send(0, mk(OP_MOVK, 2'd3, 16'h1234, 5'd5), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h1234_0000_0000_00FF, 1'b1, 1'b0);

    // Backpressure: outputs frozen for three cycles
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd8), 2'd0, 2'd0, 1'b0, 1'b1, 64'hDEAD, 64'h0, 64'h0, 64'hDEAD, 1'b1, 1'b0);
    ordy = 1'b0;
    inst = mk(OP_ADD, 2'd0, 16'h0, 5'd9); alu = 64'h5555; iv64 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(if64.in_ready), 64'd0);
      chk("bp_w_valid", 64'(if64.w_valid), 64'd1);
      chk("bp_w_data", if64.w_data, 64'hDEAD);
      chk("bp_w_addr", 64'(if64.w_addr), 64'd8);
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd9), 2'd0, 2'd0, 1'b0, 1'b1, 64'h5555, 64'h0, 64'h0, 64'h5555, 1'b1, 1'b0);

    // XZR and RegWrite=0 still produce a valid result with w_en low
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd31), 2'd0, 2'd0, 1'b0, 1'b1, 64'h77, 64'h0, 64'h0, 64'h77, 1'b0, 1'b0);
    send(0, mk(OP_ADD, 2'd0, 16'h0, 5'd10), 2'd2, 2'd0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);

    // WORD=32: illegal hw, legal MOVs, loads
    send(1, mk(OP_MOVZ, 2'd3, 16'hABCD, 5'd2), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    send(1, mk(OP_MOVZ, 2'd1, 16'hBEEF, 5'd2), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'hBEEF_0000, 1'b1, 1'b0);
    send(1, mk(OP_MOVN, 2'd0, 16'h0001, 5'd2), 2'd0, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFE, 1'b1, 1'b0);
    send(1, mk(OP_ADD, 2'd0, 16'h0, 5'd1), 2'd1, 2'd2, 1'b1, 1'b1, 64'h0, 64'h8000_0000, 64'h0, 64'h8000_0000, 1'b1, 1'b0);
    send(1, mk(OP_ADD, 2'd0, 16'h0, 5'd1), 2'd1, 2'd0, 1'b1, 1'b1, 64'h0, 64'h80F0, 64'h0, 64'hFFFF_FFF0, 1'b1, 1'b0);

    // Async reset between edges discards the held WORD=32 result
    send(1, mk(OP_ADD, 2'd0, 16'h0, 5'd3), 2'd0, 2'd0, 1'b0, 1'b1, 64'h42, 64'h0, 64'h0, 64'h42, 1'b1, 1'b0);
    ordy = 1'b0;
    @(negedge clk);
    chk("pre_rst_data32", 64'(if32.w_data), 64'h42);
    #2 rst = 1'b1;
    #1;
    chk("arst_w_valid32", 64'(if32.w_valid), 64'd0);
    chk("arst_w_data32", 64'(if32.w_data), 64'd0);
    q32.delete();
    @(posedge clk); #1;
    rst = 1'b0; ordy = 1'b1;
    send(1, mk(OP_ADD, 2'd0, 16'h0, 5'd4), 2'd2, 2'd0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q64_drained", 64'(q64.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("idle_w_valid", 64'(if64.w_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
